// File: rtl/mtc_ppa_pkg.sv
// Shared types, default sizes and helpers for the slot controller.
package mtc_ppa_pkg;

    localparam int DEF_WIDTH_N  = 8;
    localparam int DEF_AMOUNT_M = 2;
    // Widest vector the popcount helper accepts; callers zero-extend.
    localparam int POP_MAX      = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2
    } slot_state_t;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            if (v[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mtc_ppa_rr_pick.sv
// Rotating multi-pick: starting at ptr_i, walk pending_i upward with
// wrap-around and take the first free_i set bits. last_idx_o is the index
// of the final bit taken in scan order (0 when nothing is taken).
module mtc_ppa_rr_pick
    import mtc_ppa_pkg::*;
#(
    parameter  int WIDTH_N  = DEF_WIDTH_N,
    parameter  int AMOUNT_M = DEF_AMOUNT_M,
    localparam int PW       = $clog2(WIDTH_N),
    localparam int CW       = $clog2(AMOUNT_M + 1)
) (
    input  logic [WIDTH_N-1:0] pending_i,
    input  logic [PW-1:0]      ptr_i,
    input  logic [CW-1:0]      free_i,
    output logic [WIDTH_N-1:0] pick_o,
    output logic [PW-1:0]      last_idx_o
);

    // Scan all WIDTH_N positions once in rotated order, modulo WIDTH_N.
    always_comb begin : pick_scan
        int taken;
        int idx;
        pick_o     = '0;
        last_idx_o = '0;
        taken      = 0;
        idx        = 0;
        for (int k = 0; k < WIDTH_N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= WIDTH_N) idx = idx - WIDTH_N;
            if (pending_i[idx] && (taken < int'(free_i))) begin
                pick_o[idx] = 1'b1;
                last_idx_o  = PW'(idx);
                taken       = taken + 1;
            end
        end
    end

endmodule

// File: rtl/mtc_ppa_slot_ctrl.sv
// Slot controller: hands out up to AMOUNT_M shared slots to WIDTH_N
// requesters in rotating order, issuing each batch of new grants through a
// valid/ready handshake.
// Handshake: gnt_new_o is offered while gnt_vld_o is high and is held
// unchanged until a cycle where gnt_vld_o and gnt_rdy_i are both high; that
// rising edge is the transfer, and the grants become held at the same edge.
module mtc_ppa_slot_ctrl
    import mtc_ppa_pkg::*;
#(
    parameter  int WIDTH_N  = DEF_WIDTH_N,
    parameter  int AMOUNT_M = DEF_AMOUNT_M,
    localparam int PW       = $clog2(WIDTH_N),
    localparam int CW       = $clog2(AMOUNT_M + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH_N-1:0] req_i,
    input  logic [WIDTH_N-1:0] rel_i,
    output logic [WIDTH_N-1:0] gnt_new_o,
    output logic               gnt_vld_o,
    input  logic               gnt_rdy_i,
    output logic [WIDTH_N-1:0] held_o,
    output logic [CW-1:0]      busy_cnt_o,
    output logic               full_o,
    output slot_state_t        dbg_state_o,
    output logic [PW-1:0]      dbg_ptr_o
);

    slot_state_t        state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      last_q, last_d;
    logic [WIDTH_N-1:0] held_q, held_d;
    logic [WIDTH_N-1:0] gnt_new_q, gnt_new_d;

    logic [WIDTH_N-1:0] pending;
    logic [CW-1:0]      busy_cnt;
    logic [CW-1:0]      free;
    logic [WIDTH_N-1:0] pick;
    logic [PW-1:0]      pick_last;
    logic               hs;

    // Requests already holding a slot, or releasing this cycle, are not eligible.
    assign pending  = req_i & ~held_q & ~rel_i;
    assign busy_cnt = CW'(popcount(POP_MAX'(held_q)));
    assign free     = CW'(AMOUNT_M) - busy_cnt;
    assign hs       = (state_q == ST_ISSUE) && gnt_rdy_i;

    mtc_ppa_rr_pick #(
        .WIDTH_N  (WIDTH_N),
        .AMOUNT_M (AMOUNT_M)
    ) u_pick (
        .pending_i  (pending),
        .ptr_i      (ptr_q),
        .free_i     (free),
        .pick_o     (pick),
        .last_idx_o (pick_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; an empty pick in ARB falls back to IDLE silently.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if ((pending != '0) && (free != '0)) state_d = ST_ARB;
            ST_ARB:   state_d = (pick != '0) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: if (hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode, from registers only.
    always_comb begin
        gnt_vld_o   = (state_q == ST_ISSUE);
        gnt_new_o   = gnt_new_q;
        held_o      = held_q;
        busy_cnt_o  = busy_cnt;
        full_o      = (busy_cnt == CW'(AMOUNT_M));
        dbg_state_o = state_q;
        dbg_ptr_o   = ptr_q;
    end

    // Datapath next values: releases always apply; the batch is captured in
    // ARB and merged into held on the handshake (a same-cycle release of a
    // freshly granted bit cannot clear it because the OR comes last).
    always_comb begin
        held_d    = held_q & ~rel_i;
        ptr_d     = ptr_q;
        gnt_new_d = gnt_new_q;
        last_d    = last_q;
        if (state_q == ST_ARB) begin
            gnt_new_d = pick;
            last_d    = pick_last;
        end
        if (hs) begin
            held_d = (held_q & ~rel_i) | gnt_new_q;
            ptr_d  = (last_q == PW'(WIDTH_N - 1)) ? '0 : last_q + PW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q    <= '0;
            ptr_q     <= '0;
            gnt_new_q <= '0;
            last_q    <= '0;
        end else begin
            held_q    <= held_d;
            ptr_q     <= ptr_d;
            gnt_new_q <= gnt_new_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_mtc_ppa_slot_ctrl.sv
// Directed bench for the slot controller with 8 requesters and 2 slots.
module tb_mtc_ppa_slot_ctrl;
    import mtc_ppa_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  req_i;
    logic [7:0]  rel_i;
    logic [7:0]  gnt_new_o;
    logic        gnt_vld_o;
    logic        gnt_rdy_i;
    logic [7:0]  held_o;
    logic [1:0]  busy_cnt_o;
    logic        full_o;
    slot_state_t dbg_state_o;
    logic [2:0]  dbg_ptr_o;

    int tests;
    int fails;

    mtc_ppa_slot_ctrl #(.WIDTH_N(8), .AMOUNT_M(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .rel_i       (rel_i),
        .gnt_new_o   (gnt_new_o),
        .gnt_vld_o   (gnt_vld_o),
        .gnt_rdy_i   (gnt_rdy_i),
        .held_o      (held_o),
        .busy_cnt_o  (busy_cnt_o),
        .full_o      (full_o),
        .dbg_state_o (dbg_state_o),
        .dbg_ptr_o   (dbg_ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] held, input logic [1:0] busy,
                             input logic full, input logic vld, input logic [2:0] ptr);
        check({tag, ".held"}, 32'(held_o), 32'(held));
        check({tag, ".busy"}, 32'(busy_cnt_o), 32'(busy));
        check({tag, ".full"}, 32'(full_o), 32'(full));
        check({tag, ".vld"},  32'(gnt_vld_o), 32'(vld));
        check({tag, ".ptr"},  32'(dbg_ptr_o), 32'(ptr));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        req_i     = 8'h00;
        rel_i     = 8'h00;
        gnt_rdy_i = 1'b0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            req_i     = 8'($urandom_range(0, 255));
            rel_i     = 8'($urandom_range(0, 255));
            gnt_rdy_i = 1'($urandom_range(0, 1));
            tick();
        end
        check_all("rst_hi", 8'h00, 2'd0, 1'b0, 1'b0, 3'd0);
        check("rst_hi.gnt", 32'(gnt_new_o), 32'h0);
        check("rst_hi.state", 32'(dbg_state_o), 32'(ST_IDLE));
        reset = 1'b0;
        req_i = 8'h00;
        rel_i = 8'h00;
        gnt_rdy_i = 1'b0;
        tick();
        check_all("rst_rel", 8'h00, 2'd0, 1'b0, 1'b0, 3'd0);

        // Two grants from ptr 0: bits 0 and 4.
        req_i = 8'hB1;
        gnt_rdy_i = 1'b1;
        tick();
        check("s2.arb_vld", 32'(gnt_vld_o), 32'h0);
        tick();
        check("s2.vld", 32'(gnt_vld_o), 32'h1);
        check("s2.gnt", 32'(gnt_new_o), 32'h11);
        tick();
        check_all("s2.done", 8'h11, 2'd2, 1'b1, 1'b0, 3'd5);

        // Full: no further grant while requests remain.
        tick();
        check("s3.full_vld0", 32'(gnt_vld_o), 32'h0);
        tick();
        check("s3.full_vld1", 32'(gnt_vld_o), 32'h0);
        rel_i = 8'h01;
        tick();
        check("s3.rel_held", 32'(held_o), 32'h10);
        rel_i = 8'h00;
        tick();
        check("s3.arb_vld", 32'(gnt_vld_o), 32'h0);
        tick();
        check("s3.vld", 32'(gnt_vld_o), 32'h1);
        check("s3.gnt", 32'(gnt_new_o), 32'h20);
        tick();
        check_all("s3.done", 8'h30, 2'd2, 1'b1, 1'b0, 3'd6);

        // Wrap from ptr 6: bits 6 then 0.
        req_i = 8'h00;
        rel_i = 8'h30;
        tick();
        check("s4.empty", 32'(held_o), 32'h0);
        rel_i = 8'h00;
        req_i = 8'h41;
        tick();
        tick();
        check("s4.vld", 32'(gnt_vld_o), 32'h1);
        check("s4.gnt", 32'(gnt_new_o), 32'h41);
        tick();
        check_all("s4.done", 8'h41, 2'd2, 1'b1, 1'b0, 3'd1);

        // Backpressure: three stalled ISSUE cycles.
        req_i = 8'h00;
        rel_i = 8'h01;
        tick();
        rel_i = 8'h00;
        req_i = 8'h0C;
        gnt_rdy_i = 1'b0;
        tick();
        tick();
        check("s5.gnt0", 32'(gnt_new_o), 32'h04);
        check("s5.held0", 32'(held_o), 32'h40);
        tick();
        check("s5.gnt1", 32'(gnt_new_o), 32'h04);
        check("s5.vld1", 32'(gnt_vld_o), 32'h1);
        check("s5.held1", 32'(held_o), 32'h40);
        req_i = 8'hFF;
        tick();
        check("s5.gnt2", 32'(gnt_new_o), 32'h04);
        check("s5.held2", 32'(held_o), 32'h40);
        rel_i = 8'h40;
        tick();
        check("s5.gnt3", 32'(gnt_new_o), 32'h04);
        check("s5.vld3", 32'(gnt_vld_o), 32'h1);
        check("s5.held3", 32'(held_o), 32'h00);
        rel_i = 8'h00;
        req_i = 8'h00;
        gnt_rdy_i = 1'b1;
        tick();
        check_all("s5.done", 8'h04, 2'd1, 1'b0, 1'b0, 3'd3);

        // Release of the granted bit on the handshake edge is ignored.
        req_i = 8'h10;
        tick();
        tick();
        check("s6.gnt", 32'(gnt_new_o), 32'h10);
        rel_i = 8'h10;
        tick();
        check_all("s6.done", 8'h14, 2'd2, 1'b1, 1'b0, 3'd5);
        rel_i = 8'h00;

        // Reset asserted while a batch is waiting in ISSUE.
        rel_i = 8'h04;
        req_i = 8'h01;
        gnt_rdy_i = 1'b0;
        tick();
        rel_i = 8'h00;
        tick();
        tick();
        check("s7.vld", 32'(gnt_vld_o), 32'h1);
        check("s7.gnt", 32'(gnt_new_o), 32'h01);
        #2;
        reset = 1'b1;
        #1;
        check_all("s7.rst", 8'h00, 2'd0, 1'b0, 1'b0, 3'd0);
        check("s7.rst_gnt", 32'(gnt_new_o), 32'h0);
        check("s7.rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        tick();
        reset = 1'b0;
        req_i = 8'h81;
        gnt_rdy_i = 1'b1;

        // First arbitration after reset starts at 0; last pick 7 wraps ptr to 0.
        tick();
        tick();
        check("s8.gnt", 32'(gnt_new_o), 32'h81);
        tick();
        check_all("s8.done", 8'h81, 2'd2, 1'b1, 1'b0, 3'd0);
        req_i = 8'h00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
